// File: rtl/aphelion_pkg.sv
// rtl/aphelion_pkg.sv - Aphelion instruction formats, field positions and immediate helpers
package aphelion_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_M = 3'd1,
    FMT_F = 3'd2,
    FMT_J = 3'd3,
    FMT_B = 3'd4,
    FMT_E = 3'd5
  } fmt_e;

  localparam int RDE_LSB     = 8;
  localparam int RS1_LSB     = 12;
  localparam int RS2_LSB     = 16;
  localparam int FUNC_LSB_RM = 28;
  localparam int FUNC_LSB_F  = 12;
  localparam int FUNC_LSB_B  = 8;

  localparam int IMM_LSB_R = 20;
  localparam int IMM_LSB_M = 16;
  localparam int IMM_LSB_F = 16;
  localparam int IMM_LSB_J = 12;
  localparam int IMM_LSB_B = 12;
  localparam int IMM_LSB_E = 8;

  // Zero marks a format with no encoding (illegal type).
  function automatic logic [4:0] imm_width(fmt_e f);
    case (f)
      FMT_R:   return 5'd8;
      FMT_M:   return 5'd12;
      FMT_F:   return 5'd16;
      FMT_J:   return 5'd20;
      FMT_B:   return 5'd20;
      FMT_E:   return 5'd24;
      default: return 5'd0;
    endcase
  endfunction

  // True when imm survives truncation to w bits and sign-extension back.
  function automatic logic imm_fits(logic [23:0] imm, logic [4:0] w);
    logic signed [23:0] s;
    if (w >= 5'd24) return 1'b1;
    if (w == 5'd0) return 1'b0;
    s = $signed(imm) >>> (w - 5'd1);
    return (s == '0) || (&s);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-bundle input and instruction-word output handshakes
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  opcode;
  logic [3:0]  rde;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [3:0]  func;
  logic [23:0] imm;
  logic [2:0]  instr_type;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic        out_err;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  modport slave (
    input  in_valid, opcode, rde, rs1, rs2, func, imm, instr_type, out_ready,
    output in_ready, out_valid, instruction, out_err, enc_count, err_count
  );

  modport master (
    output in_valid, opcode, rde, rs1, rs2, func, imm, instr_type, out_ready,
    input  in_ready, out_valid, instruction, out_err, enc_count, err_count
  );
endinterface

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational packing of decoded fields into one instruction word
module instr_pack
  import aphelion_pkg::*;
(
  input  logic [7:0]  opcode,
  input  logic [3:0]  rde,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [3:0]  func,
  input  logic [23:0] imm,
  input  logic [2:0]  instr_type,
  output logic [31:0] word,
  output logic        err
);

  fmt_e        fmt;
  logic [4:0]  width;
  logic [31:0] imm_field;

  always_comb begin
    fmt       = fmt_e'(instr_type);
    width     = imm_width(fmt);
    imm_field = 32'(imm) & ((32'h1 << width) - 32'h1);
    word      = 32'(opcode);
    err       = 1'b0;
    case (fmt)
      FMT_R: word = word | (32'(rde) << RDE_LSB) | (32'(rs1) << RS1_LSB) | (32'(rs2) << RS2_LSB)
                         | (32'(func) << FUNC_LSB_RM) | (imm_field << IMM_LSB_R);
      FMT_M: word = word | (32'(rde) << RDE_LSB) | (32'(rs1) << RS1_LSB)
                         | (32'(func) << FUNC_LSB_RM) | (imm_field << IMM_LSB_M);
      FMT_F: word = word | (32'(rde) << RDE_LSB) | (32'(func) << FUNC_LSB_F) | (imm_field << IMM_LSB_F);
      FMT_J: word = word | (32'(rde) << RDE_LSB) | (imm_field << IMM_LSB_J);
      FMT_B: word = word | (32'(func) << FUNC_LSB_B) | (imm_field << IMM_LSB_B);
      FMT_E: word = word | (imm_field << IMM_LSB_E);
      default: err = 1'b1;
    endcase
    if (!imm_fits(imm, width)) err = 1'b1;
    // A flagged word must never look like a usable encoding.
    if (err) word = '0;
  end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - pipelined encoder with output register, skid entry and result counters
module instr_encoder
  import aphelion_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_e;

  buf_state_e  state, next_state;
  logic [31:0] pack_word, out_word, skid_word;
  logic        pack_err, out_err_r, skid_err;
  logic        ready_r;
  logic [15:0] enc_cnt, err_cnt;
  logic        in_fire, out_fire;
  logic        load_out_in, load_out_skid, load_skid;

  instr_pack u_pack (
    .opcode     (bus.opcode),
    .rde        (bus.rde),
    .rs1        (bus.rs1),
    .rs2        (bus.rs2),
    .func       (bus.func),
    .imm        (bus.imm),
    .instr_type (bus.instr_type),
    .word       (pack_word),
    .err        (pack_err)
  );

  assign bus.in_ready    = ready_r;
  assign bus.out_valid   = (state != EMPTY);
  assign bus.instruction = out_word;
  assign bus.out_err     = out_err_r;
  assign bus.enc_count   = enc_cnt;
  assign bus.err_count   = err_cnt;

  assign in_fire  = bus.in_valid && ready_r;
  assign out_fire = (state != EMPTY) && bus.out_ready;

  always_comb begin
    next_state    = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      EMPTY: if (in_fire) begin
        load_out_in = 1'b1;
        next_state  = ONE;
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_out_in = 1'b1;
        end else if (in_fire) begin
          load_skid  = 1'b1;
          next_state = FULL;
        end else if (out_fire) begin
          next_state = EMPTY;
        end
      end
      FULL: if (out_fire) begin
        load_out_skid = 1'b1;
        next_state    = ONE;
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      ready_r   <= 1'b1;
      out_word  <= '0;
      out_err_r <= 1'b0;
      skid_word <= '0;
      skid_err  <= 1'b0;
      enc_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      state   <= next_state;
      // Registered ready lags one cycle; the skid entry absorbs the word accepted meanwhile.
      ready_r <= (next_state != FULL);
      if (load_out_in) begin
        out_word  <= pack_word;
        out_err_r <= pack_err;
      end else if (load_out_skid) begin
        out_word  <= skid_word;
        out_err_r <= skid_err;
      end
      if (load_skid) begin
        skid_word <= pack_word;
        skid_err  <= pack_err;
      end
      if (out_fire) begin
        if (out_err_r) begin
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end else begin
          if (enc_cnt != 16'hFFFF) enc_cnt <= enc_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined instruction encoder for the Aphelion 32-bit instruction word: accepts decoded fields (opcode, registers, func, immediate, format) over a valid/ready handshake and produces the packed 32-bit instruction word. It is the inverse of the instruction decoder. It sits between the test/boot sequencer (or a JIT/patch unit) and instruction memory write-back. Fields that cannot be represented in the selected format are flagged rather than silently truncated.

## Interface
- no parameters; field positions come from the shared package
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept this cycle
- opcode  in  8  opcode
- rde  in  4  destination register
- rs1  in  4  source register 1
- rs2  in  4  source register 2
- func  in  4  function selector
- imm  in  24  immediate, two's complement
- instr_type  in  3  format: 0=R, 1=M, 2=F, 3=J, 4=B, 5=E; 6 and 7 are illegal
- out_valid  out  1  instruction valid
- out_ready  in  1  downstream accepts
- instruction  out  32  packed word
- out_err  out  1  word is invalid (see Operation)
- enc_count  out  16  words emitted with out_err=0, saturating
- err_count  out  16  words emitted with out_err=1, saturating

## Operation
- Bit layout (op always [7:0]):
  - R: rde[11:8] rs1[15:12] rs2[19:16] imm8[27:20] func[31:28]
  - M: rde[11:8] rs1[15:12] imm12[27:16] func[31:28]
  - F: rde[11:8] func[15:12] imm16[31:16]
  - J: rde[11:8] imm20[31:12]
  - B: func[11:8] imm20[31:12]
  - E: imm24[31:8]
- Fields that the format does not use are ignored.
- Immediate fit check for field width w<24:
  - imm[23:w-1] must be all-equal (sign-extension form); otherwise out_err=1.
  - E never fails the fit check.
- Illegal instr_type gives out_err=1.
- Any out_err word carries instruction=32'h0.
- Buffering is an output register plus a one-entry skid register (2 entries total).
- in_ready is registered and equals !skid_full.
- Transfer occurs on valid&&ready. Output stays stable while out_valid && !out_ready.
- Counters increment on each output handshake, selected by out_err, and saturate at 16'hFFFF.
- Buffer states:
  - EMPTY: accept into output register, go to ONE.
  - ONE:
    - output fire with no input: go to EMPTY.
    - input with no output fire: input goes to skid, go to FULL.
    - both: input goes to output register, stay in ONE.
  - FULL (in_ready=0): on output fire, skid moves to output register, go to ONE.

## Timing
- Latency: in handshake at edge N gives out_valid high after edge N.
- Throughput is 1 word/cycle when out_ready is held high.
- Reset values: out_valid=0, instruction=0, out_err=0, in_ready=1, counters=0, state EMPTY.
- Reset mid-operation drops all buffered words. No partial output appears after reset.
- in_ready deasserts only in the cycle after the skid register fills, so the skid entry absorbs the one-cycle ready lag.
- enc_count and err_count update on the same edge as the output handshake.

## Structure
- aphelion_pkg holds:
  - the format enum (FMT_R … FMT_E).
  - the field LSB/width constants for each format.
  - a function returning the immediate width per format.
- The decoder shares aphelion_pkg.
- Sub-module instr_pack: purely combinational fields→{word, err}. It is instantiated once, ahead of the output register/skid, so it can be checked against the decoder exhaustively.

## Test plan
- E, op=8'h01, imm=24'h000004 → instruction=32'h00000401, err=0, one cycle after accept.
- R, op=8'h10, rde=4, rs1=1, rs2=1, func=2, imm=0 → 32'h20011410.
- F, op=8'h13, rde=F, func=F, imm=24'h005432 → 32'h5432FF13. Same with imm=24'h008000 → err=1, instruction=0, err_count=1.
- Back-to-back 3 words with out_ready=0:
  - in_ready drops after the 2nd accept.
  - raising out_ready drains the words in order, one per cycle, and in_ready returns.
- instr_type=6 → err=1. Counter saturation: preload via 65536 accepts → enc_count stays 16'hFFFF.
- Assert rst while FULL → out_valid=0 and in_ready=1 immediately. No stale word appears after release.
